sigmoid_pipe: RTL and testbench

SIGMOID_PIPE -- requirements
Module: sigmoid_pipe

---
 rtl/sigmoid_pipe.sv | 187 ++++++++++++++++++
 tb/tb_sigmoid_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_pipe.sv
// -----------------------------------------------------------------------------
// sigmoid_pipe
//   Three-stage, valid/ready pipelined piecewise-linear sigmoid on signed
//   fixed-point data (Q(W-FRAC).FRAC). The approximation works on a = |x|:
//     a >= 5            -> 1.0
//     2.375 <= a < 5    -> a/32 + 0.84375
//     1 <= a < 2.375    -> a/8  + 0.625
//     a < 1             -> a/4  + 0.5
//   Negative inputs use the symmetry f(-a) = 1.0 - f(a). The result lies in
//   [0, 1.0], and 1.0 is encoded as 2^FRAC.
//
//   Stages: S1 abs/sign/segment select, S2 shift-add, S3 symmetry + output
//   register. The whole pipe advances only when in_ready = !out_valid |
//   out_ready. While in_ready is low, every stage register holds.
//
//   Optional feature (macro SIGMOID_TANH_EN): adds input in_mode, captured
//   with each sample. With in_mode=1 the block returns tanh(x) = 2*f(2x) - 1,
//   where 2x saturates to the W-bit range. The output range is then
//   [-1.0, 1.0]. The latency does not change.
//
//   Parameters: W (total width), FRAC (fraction bits). Legal only when
//   W-FRAC >= 4, so that 5.0 can be represented.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_x holds a sample
//   in_ready   block accepts a sample this cycle
//   in_x       signed Q(W-FRAC).FRAC argument
//   in_mode    (SIGMOID_TANH_EN only) 1 = tanh, 0 = sigmoid
//   out_valid  out_y holds a result
//   out_ready  downstream accepts out_y this cycle
//   out_y      signed Q(W-FRAC).FRAC result, driven from a register
// -----------------------------------------------------------------------------
module sigmoid_pipe #(
  parameter int W    = 8,
  parameter int FRAC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
`ifdef SIGMOID_TANH_EN
  input  logic         in_mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y
);

  typedef enum logic [1:0] {SEG_LO, SEG_MID, SEG_HI, SEG_SAT} seg_e;

  localparam int ONE_I     = 2 ** FRAC;
  localparam int FIVE_I    = 5 * ONE_I;
  // 2.375 rounded up, so that "a >= threshold" matches the real comparison.
  localparam int T_HI_I    = (19 * ONE_I + 7) / 8;
  localparam int OFF_HI_I  = (27 * ONE_I) / 32;  // 0.84375, truncated
  localparam int OFF_MID_I = (5 * ONE_I) / 8;    // 0.625, truncated
  localparam int OFF_LO_I  = ONE_I / 2;          // 0.5

  localparam logic [W-1:0] C_ONE     = W'(ONE_I);
  localparam logic [W-1:0] C_FIVE    = W'(FIVE_I);
  localparam logic [W-1:0] C_T_HI    = W'(T_HI_I);
  localparam logic [W-1:0] C_OFF_HI  = W'(OFF_HI_I);
  localparam logic [W-1:0] C_OFF_MID = W'(OFF_MID_I);
  localparam logic [W-1:0] C_OFF_LO  = W'(OFF_LO_I);
  localparam logic [W-1:0] C_MAX     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] C_MIN     = {1'b1, {(W-1){1'b0}}};

  // Stage registers
  logic         r_s1_valid, r_s2_valid, r_out_valid;
  logic         r_s1_neg,   r_s2_neg;
  logic [W-1:0] r_s1_abs;
  seg_e         r_s1_seg;
  logic [W-1:0] r_s2_f;
  logic [W-1:0] r_out_y;
`ifdef SIGMOID_TANH_EN
  logic         r_s1_mode, r_s2_mode;
`endif

  // Combinational stage logic
  logic         w_advance;
  logic [W-1:0] w_x_eff;
  logic         w_neg;
  logic [W-1:0] w_abs;
  seg_e         w_seg;
  logic [W-1:0] w_f;
  logic [W-1:0] w_sig;
  logic [W-1:0] w_y;

  // NOTE: in_ready depends combinationally on out_ready. This is what allows
  // full throughput. The output data path stays purely registered.
  assign in_ready  = !r_out_valid || out_ready;
  assign w_advance = in_ready;

  // ---------------- S1: optional doubling, abs, sign, segment ----------------
  // NOTE: every always_comb output gets a default first, so no latch is
  // inferred on any path.
  always_comb begin
    w_x_eff = in_x;
`ifdef SIGMOID_TANH_EN
    if (in_mode) begin
      // If the top two bits differ, 2x overflows: saturate to MAX or MIN.
      if (in_x[W-1] != in_x[W-2]) w_x_eff = in_x[W-1] ? C_MIN : C_MAX;
      else                        w_x_eff = {in_x[W-2:0], 1'b0};
    end
`endif
  end

  assign w_neg = w_x_eff[W-1];

  always_comb begin
    w_abs = w_x_eff;
    if (w_neg) begin
      // |MIN| is not representable, so clamp it to MAX. MAX falls in the
      // saturated segment anyway.
      if (w_x_eff == C_MIN) w_abs = C_MAX;
      else                  w_abs = -w_x_eff;
    end
  end

  always_comb begin
    w_seg = SEG_LO;
    if      (w_abs >= C_FIVE) w_seg = SEG_SAT;
    else if (w_abs >= C_T_HI) w_seg = SEG_HI;
    else if (w_abs >= C_ONE)  w_seg = SEG_MID;
  end

  // ---------------- S2: shift-add per segment --------------------------------
  // The magnitude is non-negative. A logical shift therefore equals the
  // arithmetic shift and truncates toward zero.
  always_comb begin
    w_f = C_ONE;
    case (r_s1_seg)
      SEG_SAT: w_f = C_ONE;
      SEG_HI:  w_f = (r_s1_abs >> 5) + C_OFF_HI;
      SEG_MID: w_f = (r_s1_abs >> 3) + C_OFF_MID;
      default: w_f = (r_s1_abs >> 2) + C_OFF_LO;
    endcase
  end

  // ---------------- S3: symmetry (and tanh rescale) --------------------------
  assign w_sig = r_s2_neg ? (C_ONE - r_s2_f) : r_s2_f;

  always_comb begin
    w_y = w_sig;
`ifdef SIGMOID_TANH_EN
    if (r_s2_mode) w_y = (w_sig << 1) - C_ONE;
`endif
  end

  // ---------------- Control and output registers -----------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= in_valid;
      r_s2_valid  <= r_s1_valid;
      r_out_valid <= r_s2_valid;
      r_out_y     <= w_y;
    end
  end

  // NOTE: the datapath registers are deliberately left unreset. Their
  // contents only matter when they are qualified by the valid bits above.
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_s1_neg  <= w_neg;
      r_s1_abs  <= w_abs;
      r_s1_seg  <= w_seg;
      r_s2_neg  <= r_s1_neg;
      r_s2_f    <= w_f;
`ifdef SIGMOID_TANH_EN
      r_s1_mode <= in_mode;
      r_s2_mode <= r_s1_mode;
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;

endmodule

// File: tb/tb_sigmoid_pipe.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_pipe
//   Bench for sigmoid_pipe (W=8, FRAC=4). A reference function computes the
//   required result straight from the piecewise definition, using integer
//   arithmetic. A negedge monitor keeps a queue of expected results. On every
//   cycle it checks the output handshake, the hold-during-stall behaviour and
//   the in_ready rule. Directed sequences then check the literal vectors, the
//   pipeline latency, mid-stream back-pressure, reset while samples are in
//   flight, and a full monotonic sweep.
// -----------------------------------------------------------------------------
module tb_sigmoid_pipe;

  localparam int W    = 8;
  localparam int FRAC = 4;
`ifdef SIGMOID_TANH_EN
  localparam bit TANH_EN = 1'b1;
`else
  localparam bit TANH_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;

  sigmoid_pipe #(.W(W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
`ifdef SIGMOID_TANH_EN
    .in_mode   (in_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int out_count = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model, written directly from the piecewise definition.
  function automatic logic [W-1:0] golden(input logic signed [W-1:0] x, input bit mode);
    int xi, a, f, s, one, lim;
    logic [31:0] r;
    one = 1 << FRAC;
    lim = 1 << (W - 1);
    xi  = x;
    if (mode) begin
      xi = 2 * xi;
      if (xi > lim - 1) xi = lim - 1;
      if (xi < -lim)    xi = -lim;
    end
    a = (xi < 0) ? -xi : xi;
    if (a > lim - 1) a = lim - 1;
    if (a >= 5 * one)          f = one;
    else if (8 * a >= 19 * one) f = a / 32 + (27 * one) / 32;
    else if (a >= one)          f = a / 8 + (5 * one) / 8;
    else                        f = a / 4 + one / 2;
    s = (xi < 0) ? one - f : f;
    if (mode) s = 2 * s - one;
    r = s;
    return r[W-1:0];
  endfunction

  // Monitor and scoreboard.
  bit           was_rst = 1'b0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] stall_y;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      was_rst    = 1'b1;
      stall_prev = 1'b0;
    end else begin
      if (was_rst) begin
        check("post_reset_out_valid", out_valid, 0);
        check("post_reset_out_y", out_y, 0);
        check("post_reset_in_ready", in_ready, 1);
        was_rst = 1'b0;
      end
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stall_prev) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_y", out_y, stall_y);
      end
      if (out_valid && out_ready) begin
        check("output_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("scoreboard_y", out_y, exp_q.pop_front());
        got_q.push_back(out_y);
        out_count++;
      end
      stall_prev = out_valid && !out_ready;
      stall_y    = out_y;
      if (in_valid && in_ready) exp_q.push_back(golden(in_x, TANH_EN && in_mode));
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Call this aligned to posedge+1. It returns at posedge+1 after acceptance.
  task automatic send(input logic [W-1:0] x, input bit m);
    int waited = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int bad;
    logic [W-1:0] v;
    logic [W-1:0] stream_v[8] = '{8'h00, 8'h26, 8'h25, 8'h50, 8'h4F, 8'hDA, 8'hB0, 8'h7F};

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_mode = 1'b0; out_ready = 1'b1;

    // Hand-computed literals that pin the reference model.
    check("model_00", golden(8'h00, 0), 8'h08);
    check("model_70", golden(8'h70, 0), 8'h10);
    check("model_90", golden(8'h90, 0), 8'h00);
    check("model_10", golden(8'h10, 0), 8'h0C);
    check("model_F0", golden(8'hF0, 0), 8'h04);
    check("model_08", golden(8'h08, 0), 8'h0A);
    check("model_80", golden(8'h80, 0), 8'h00);
    check("model_26", golden(8'h26, 0), 8'h0E);
    check("model_25", golden(8'h25, 0), 8'h0E);
    check("model_4F", golden(8'h4F, 0), 8'h0F);
    check("model_50", golden(8'h50, 0), 8'h10);
    check("model_tanh_10", golden(8'h10, 1), 8'h0C);
    check("model_tanh_7F", golden(8'h7F, 1), 8'h10);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Consecutive samples, with cycle-exact latency.
    sync();
    in_valid = 1'b1; in_x = 8'h00; in_mode = 1'b0;
    @(negedge clk); check("lat_c0_valid", out_valid, 0);
    @(posedge clk); #1 in_x = 8'h70;
    @(negedge clk); check("lat_c1_valid", out_valid, 0);
    @(posedge clk); #1 in_x = 8'h90;
    @(negedge clk); check("lat_c2_valid", out_valid, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check("lat_c3_valid", out_valid, 1); check("lat_c3_y", out_y, 8'h08);
    @(negedge clk); check("lat_c4_valid", out_valid, 1); check("lat_c4_y", out_y, 8'h10);
    @(negedge clk); check("lat_c5_valid", out_valid, 1); check("lat_c5_y", out_y, 8'h00);

    // Unit points, both signs, and the most-negative input.
    sync();
    base = got_q.size();
    send(8'h10, 0); send(8'hF0, 0); send(8'h08, 0); send(8'h80, 0);
    drain("drain_vec");
    check("vec_count", got_q.size() - base, 4);
    check("vec_10", got_q[base],   8'h0C);
    check("vec_F0", got_q[base+1], 8'h04);
    check("vec_08", got_q[base+2], 8'h0A);
    check("vec_80", got_q[base+3], 8'h00);

    // Stream of 8 samples, with out_ready low for 4 cycles mid-stream.
    sync();
    base = out_count;
    fork
      begin
        for (int i = 0; i < 8; i++) send(stream_v[i], 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_stream");
    check("stream_count", out_count - base, 8);

    // Reset with 3 samples in flight. None of them may ever appear.
    sync();
    out_ready = 1'b0;
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 0);
    base = out_count;
    rst = 1'b1; in_valid = 1'b1; in_x = 8'h40;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("reset_discard_count", out_count - base, 0);
    check("reset_queue_empty", exp_q.size(), 0);

    // Exhaustive ascending sweep, from -128 to 127.
    sync();
    base = got_q.size();
    for (int i = 0; i < 256; i++) begin
      v = W'(i);
      v[W-1] = ~v[W-1];
      send(v, 0);
    end
    drain("drain_sweep");
    check("sweep_count", got_q.size() - base, 256);
    bad = 0;
    for (int k = 1; k < 256; k++)
      if (got_q[base+k] < got_q[base+k-1]) bad++;
    check("sweep_monotonic_violations", bad, 0);

`ifdef SIGMOID_TANH_EN
    // tanh mode, followed by a sigmoid sample to show that the mode is
    // captured per sample.
    sync();
    base = got_q.size();
    send(8'h00, 1); send(8'h10, 1); send(8'h7F, 1); send(8'h10, 0);
    drain("drain_tanh");
    check("tanh_00", got_q[base],   8'h00);
    check("tanh_10", got_q[base+1], 8'h0C);
    check("tanh_7F", got_q[base+2], 8'h10);
    check("tanh_then_sig_10", got_q[base+3], 8'h0C);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
